// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared state encodings and defaults for the CPU+IO step controller.
package cpu_io_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN = 2'b01;
  localparam logic [1:0] ST_BREAK = 2'b10;
  localparam logic [23:0] DEFAULT_RUN_DIV = 24'd5_000_000;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN = ST_RUN,
    S_BREAK = ST_BREAK,
    S_BAD = 2'b11
  } state_e;
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: one-cycle rise event from a debounced level button.
module btn_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic btn_i,
  output logic rise_o
);
  logic prev_q;
  always_ff @(posedge Clock) prev_q <= Reset ? 1'b0 : btn_i;
  assign rise_o = btn_i & ~prev_q;
endmodule

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: single-step / free-run / PC-breakpoint clock-enable sequencer.
module cpu_step_controller
  import cpu_io_pkg::*;
#(
  parameter logic [23:0] RUN_DIV = DEFAULT_RUN_DIV,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 BtnStep,
  input  logic                 BtnRun,
  input  logic                 BreakEn,
  input  logic [31:0]          BreakAddr,
  input  logic [31:0]          PC,
  output logic                 CpuClkEn,
  output logic [1:0]           State,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] StepCount
);
  state_e state_q, state_d;
  logic [23:0] div_q, div_d;
  logic pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic step_rise, run_rise, tc, brk;
  btn_edge_detect u_step (.Clock(Clock), .Reset(Reset), .btn_i(BtnStep), .rise_o(step_rise));
  btn_edge_detect u_run (.Clock(Clock), .Reset(Reset), .btn_i(BtnRun), .rise_o(run_rise));
  assign tc = div_q == RUN_DIV - 24'd1;
  assign brk = BreakEn && PC == BreakAddr;
  // run toggle has priority over step and over a coincident terminal count
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = run_rise ? S_RUN : S_IDLE;
        div_d = run_rise ? 24'd0 : div_q;
        pulse_d = step_rise & ~run_rise;
      end
      S_RUN: begin
        state_d = run_rise ? S_IDLE : (tc && brk) ? S_BREAK : S_RUN;
        div_d = (run_rise || tc) ? 24'd0 : div_q + 24'd1;
        pulse_d = ~run_rise & tc & ~brk;
      end
      S_BREAK: begin
        state_d = run_rise ? S_RUN : S_BREAK;
        div_d = run_rise ? 24'd0 : div_q;
        pulse_d = run_rise | step_rise;
      end
      default: begin
        state_d = S_IDLE;
        div_d = 24'd0;
      end
    endcase
  end
  assign cnt_d = (pulse_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      div_q <= 24'd0;
      pulse_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      pulse_q <= pulse_d;
      cnt_q <= cnt_d;
    end
  end
  assign CpuClkEn = pulse_q;
  assign State = state_q;
  assign Halted = state_q == S_BREAK;
  assign StepCount = cnt_q;
endmodule
